if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage CPU; directly upstream of the decode-stage control unit.
- Holds the PC, drives the instruction-memory address, and latches the fetched word plus PC+4 into IF/ID.
- Applies control-hazard redirects (branch/jump) that decode reports through pcsource: squashes the wrong-path fetch and reloads the PC.
- Handles the load-use stall and enters a halted state on an illegal-instruction code.

---
 rtl/if_stage_if.sv | 16 +
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// Read is combinational: imem_data answers imem_addr in the same cycle.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );
endinterface

// File: rtl/if_stage.sv
// Fetch stage: PC register, imem addressing and the IF/ID pipeline register.
// Handles branch/jump redirects, load-use stall and illegal-code halt.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             stall,
  input  logic [1:0]       pcsource,
  input  logic [31:0]      bpc,
  input  logic [31:0]      jpc,
  if_stage_if.master       imem,
  output logic [31:0]      pc,
  output logic [31:0]      inst_id,
  output logic [31:0]      pc4_id,
  output logic             valid_id,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {
    RUN,
    HALT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       eff_sel;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] cnt_inc;
  logic             halt_c, hold_c, go_c;
  logic             br_c, jp_c, il_c, seq_c;

  // A bubble in IF/ID must not redirect: its pcsource is meaningless.
  assign eff_sel  = valid_q ? pcsource : 2'b00;
  assign pc_plus4 = pc_q + 32'd4;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  assign halt_c = (state_q == HALT);
  assign hold_c = !halt_c && stall;
  assign go_c   = !halt_c && !stall;
  assign br_c   = go_c && (eff_sel == 2'b01);
  assign jp_c   = go_c && (eff_sel == 2'b10);
  assign il_c   = go_c && (eff_sel == 2'b11);
  assign seq_c  = go_c && (eff_sel == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      halt_c: begin
        inst_d  = 32'h0;
        valid_d = 1'b0;
      end
      hold_c: begin
      end
      br_c: begin
        pc_d    = {bpc[31:2], 2'b00};
        inst_d  = 32'h0;
        valid_d = 1'b0;
        cnt_d   = cnt_inc;
      end
      jp_c: begin
        pc_d    = {jpc[31:2], 2'b00};
        inst_d  = 32'h0;
        valid_d = 1'b0;
        cnt_d   = cnt_inc;
      end
      il_c: begin
        state_d = HALT;
        inst_d  = 32'h0;
        valid_d = 1'b0;
      end
      seq_c: begin
        pc_d    = pc_plus4;
        inst_d  = imem.imem_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign inst_id        = inst_q;
  assign pc4_id         = pc4_q;
  assign valid_id       = valid_q;
  assign halted         = (state_q == HALT);
  assign redirect_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed hazard scenarios then random traffic.
// Imem returns addr|1 so every fetched word identifies its address.
module tb_if_stage;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic             stall = 1'b0;
  logic [1:0]       pcsource = 2'b00;
  logic [31:0]      bpc = 32'h0;
  logic [31:0]      jpc = 32'h0;
  logic [31:0]      pc, inst_id, pc4_id;
  logic             valid_id, halted;
  logic [CNT_W-1:0] redirect_cnt;

  if_stage_if bus ();
  assign bus.imem_data = bus.imem_addr | 32'h1;

  if_stage #(
    .RESET_PC (32'h0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .clrn         (clrn),
    .stall        (stall),
    .pcsource     (pcsource),
    .bpc          (bpc),
    .jpc          (jpc),
    .imem         (bus.master),
    .pc           (pc),
    .inst_id      (inst_id),
    .pc4_id       (pc4_id),
    .valid_id     (valid_id),
    .halted       (halted),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic        halt;
    int          cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, a, e);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("imem_addr", bus.imem_addr, e.pc);
        chk("inst_id", inst_id, e.inst);
        chk("pc4_id", pc4_id, e.pc4);
        chk("valid_id", {31'h0, valid_id}, {31'h0, e.valid});
        chk("halted", {31'h0, halted}, {31'h0, e.halt});
        chk("redirect_cnt", 32'(redirect_cnt), 32'(e.cnt));
      end
    end
  end

  function automatic void model_reset();
    m.pc = 32'h0; m.inst = 32'h0; m.pc4 = 32'h0;
    m.valid = 1'b0; m.halt = 1'b0; m.cnt = 0;
  endfunction

  // One clock of stimulus; expected post-edge state goes to the scoreboard.
  task automatic step(input logic st, input logic [1:0] sel,
                      input logic [31:0] b, input logic [31:0] j,
                      input logic rst);
    logic [1:0] eff;
    @(negedge clk);
    stall = st; pcsource = sel; bpc = b; jpc = j;
    clrn = !rst;
    if (rst) begin
      model_reset();
    end else begin
      eff = m.valid ? sel : 2'b00;
      if (m.halt) begin
        m.inst = 0; m.valid = 0;
      end else if (!st) begin
        if (eff == 2'b01 || eff == 2'b10) begin
          m.pc = (eff == 2'b01) ? (b & ~32'h3) : (j & ~32'h3);
          m.inst = 0; m.valid = 0;
          if (m.cnt < CMAX) m.cnt++;
        end else if (eff == 2'b11) begin
          m.halt = 1; m.inst = 0; m.valid = 0;
        end else begin
          m.inst = m.pc | 32'h1;
          m.pc = m.pc + 32'd4;
          m.pc4 = m.pc;
          m.valid = 1;
        end
      end
    end
    q.push_back(m);
  endtask

  initial begin
    int hcnt;
    logic [31:0] r;
    logic [1:0] s;
    model_reset();
    step(0, 2'b00, 0, 0, 1);
    step(0, 2'b00, 0, 0, 1);
    repeat (3) step(0, 2'b00, 0, 0, 0);
    step(0, 2'b01, 32'h40, 0, 0);
    step(0, 2'b01, 32'h80, 0, 0);
    step(0, 2'b00, 0, 0, 0);
    step(0, 2'b10, 0, 32'h103, 0);
    step(0, 2'b00, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0);
    step(1, 2'b01, 32'h200, 0, 0);
    step(1, 2'b01, 32'h200, 0, 0);
    step(0, 2'b01, 32'h200, 0, 0);
    step(0, 2'b00, 0, 0, 0);
    repeat (6) begin
      step(0, 2'b01, 32'hFFFF_FFFC, 0, 0);
      step(0, 2'b00, 0, 0, 0);
    end
    step(0, 2'b00, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0);
    step(0, 2'b11, 0, 0, 0);
    repeat (10) begin
      r = $urandom;
      step(r[0], r[2:1], $urandom, $urandom, 0);
    end
    step(0, 2'b00, 0, 0, 1);
    step(0, 2'b00, 0, 0, 0);
    hcnt = 0;
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 70) s = 2'b00;
      else if (r < 83) s = 2'b01;
      else if (r < 97) s = 2'b10;
      else s = 2'b11;
      hcnt = m.halt ? hcnt + 1 : 0;
      step($urandom_range(0, 99) < 15, s,
           ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom,
           $urandom,
           ($urandom_range(0, 199) == 0) || hcnt > 8);
    end
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
